// File: rtl/simple_bus.sv
// simple_bus -- single-cycle crossbar from NrHosts initiators to NrDevices
// targets with fixed-priority arbitration and mask/base address decode.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   host_*_i / host_*_o    per-host request channel (req/we/addr/be/wdata)
//                          and grant/response channel (gnt/rvalid/err/rdata)
//   device_*_o / device_*_i per-device request channel and response channel
//   cfg_device_addr_base/mask  per-device address window:
//                          hit when (addr & mask) == base
//
// Optional feature (macro SIMPLE_BUS_DECODE_ERR_EN):
//   defined   -> an unmapped request reaches no device and the bus itself
//                answers next cycle with rvalid=1, err=1, rdata=0
//   undefined -> an unmapped request falls through to device 0
//
// Requests are granted combinationally in the cycle they are presented; the
// winning host/device pair is captured so the one-cycle-later device response
// can be steered back to the right host.

// Per-device window match.
module simple_bus_dev_match #(
  parameter int AddressWidth = 32
) (
  input  logic [AddressWidth-1:0] addr,
  input  logic [AddressWidth-1:0] base,
  input  logic [AddressWidth-1:0] mask,
  output logic                    match
);
  assign match = ((addr & mask) == base);
endmodule

module simple_bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  // hosts
  input  logic [NrHosts-1:0]                       host_req_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [NrHosts-1:0]                       host_err_o,
  output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
  // devices
  output logic [NrDevices-1:0]                     device_req_o,
  output logic [NrDevices-1:0]                     device_we_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
  input  logic [NrDevices-1:0]                     device_rvalid_i,
  input  logic [NrDevices-1:0]                     device_err_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
  // address map
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask
);

  // Index widths stay at least 1 bit so single-port builds still elaborate.
  localparam int HIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
  localparam int DIdxW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  // ---------------------------------------------------------------------------
  // Arbitration: lowest-index requester wins, host 0 when idle
  // ---------------------------------------------------------------------------
  logic [HIdxW-1:0] host_sel;

  always_comb begin
    logic found;
    host_sel = '0;
    found    = 1'b0;
    for (int h = 0; h < NrHosts; h++) begin
      if (!found && host_req_i[h]) begin
        host_sel = HIdxW'(h);
        found    = 1'b1;
      end
    end
  end

  // Selected host's request fields.
  logic                    sel_req;
  logic                    sel_we;
  logic [AddressWidth-1:0] sel_addr;
  logic [DataWidth/8-1:0]  sel_be;
  logic [DataWidth-1:0]    sel_wdata;

  always_comb begin
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (HIdxW'(h) == host_sel) begin
        sel_req   = host_req_i[h];
        sel_we    = host_we_i[h];
        sel_addr  = host_addr_i[h];
        sel_be    = host_be_i[h];
        sel_wdata = host_wdata_i[h];
      end
    end
  end

  always_comb begin
    host_gnt_o = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (HIdxW'(h) == host_sel) host_gnt_o[h] = sel_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode: one matcher per device, lowest-index hit wins
  // ---------------------------------------------------------------------------
  logic [NrDevices-1:0] dev_match;

  for (genvar d = 0; d < NrDevices; d++) begin : g_match
    simple_bus_dev_match #(
      .AddressWidth (AddressWidth)
    ) u_match (
      .addr  (sel_addr),
      .base  (cfg_device_addr_base[d]),
      .mask  (cfg_device_addr_mask[d]),
      .match (dev_match[d])
    );
  end

  logic [DIdxW-1:0] dev_sel;
  logic             dev_hit;

  // A miss leaves dev_sel at 0, which is the fall-through target when
  // decode errors are disabled.
  always_comb begin
    dev_sel = '0;
    dev_hit = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (!dev_hit && dev_match[d]) begin
        dev_sel = DIdxW'(d);
        dev_hit = 1'b1;
      end
    end
  end

  logic route_en;
`ifdef SIMPLE_BUS_DECODE_ERR_EN
  assign route_en = dev_hit;
`else
  assign route_en = 1'b1;
  logic unused_dev_hit;
  assign unused_dev_hit = dev_hit;
`endif

  // Request fields fan out to every device; only req is steered.
  for (genvar d = 0; d < NrDevices; d++) begin : g_dev_out
    assign device_req_o[d]   = sel_req & route_en & (dev_sel == DIdxW'(d));
    assign device_we_o[d]    = sel_we;
    assign device_addr_o[d]  = sel_addr;
    assign device_be_o[d]    = sel_be;
    assign device_wdata_o[d] = sel_wdata;
  end

  // ---------------------------------------------------------------------------
  // Response routing state. Indices hold across idle cycles; only a grant
  // moves them.
  // ---------------------------------------------------------------------------
  logic [HIdxW-1:0] host_q;
  logic [DIdxW-1:0] dev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_q <= '0;
      dev_q  <= '0;
    end else if (sel_req) begin
      host_q <= host_sel;
      dev_q  <= dev_sel;
    end
  end

`ifdef SIMPLE_BUS_DECODE_ERR_EN
  // One-cycle flag: last cycle's grant hit no device, so the bus answers.
  logic derr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) derr_q <= 1'b0;
    else         derr_q <= sel_req & ~dev_hit;
  end
`endif

  // Registered device's response.
  logic                 rsp_valid;
  logic                 rsp_err;
  logic [DataWidth-1:0] rsp_data;

  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (DIdxW'(d) == dev_q) begin
        rsp_valid = device_rvalid_i[d];
        rsp_err   = device_err_i[d];
        rsp_data  = device_rdata_i[d];
      end
    end
`ifdef SIMPLE_BUS_DECODE_ERR_EN
    if (derr_q) begin
      rsp_valid = 1'b1;
      rsp_err   = 1'b1;
      rsp_data  = '0;
    end
`endif
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (HIdxW'(h) == host_q) begin
        host_rvalid_o[h] = rsp_valid;
        host_err_o[h]    = rsp_err;
        host_rdata_o[h]  = rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// tb_simple_bus -- directed + randomized bench for simple_bus with 2 hosts and
// 3 devices. A transaction-level reference (priority pick, window lookup, last
// grant remembered) predicts every output each cycle. Follows the decode-error
// macro SIMPLE_BUS_DECODE_ERR_EN when the build defines it.
module tb_simple_bus;
  localparam int NH = 2, ND = 3, DW = 32, AW = 32;
`ifdef SIMPLE_BUS_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NH-1:0]                host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [NH-1:0][AW-1:0]        host_addr;
  logic [NH-1:0][DW/8-1:0]      host_be;
  logic [NH-1:0][DW-1:0]        host_wdata, host_rdata;
  logic [ND-1:0]                dev_req, dev_we, dev_rvalid, dev_err;
  logic [ND-1:0][AW-1:0]        dev_addr, cfg_base, cfg_mask;
  logic [ND-1:0][DW/8-1:0]      dev_be;
  logic [ND-1:0][DW-1:0]        dev_wdata, dev_rdata;

  simple_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err),
    .host_rdata_o(host_rdata),
    .device_req_o(dev_req), .device_we_o(dev_we), .device_addr_o(dev_addr),
    .device_be_o(dev_be), .device_wdata_o(dev_wdata),
    .device_rvalid_i(dev_rvalid), .device_err_i(dev_err), .device_rdata_i(dev_rdata),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  int tests = 0, fails = 0;

  // Reference state: who got the last grant, and whether it was unmapped.
  int rh = 0, rd = 0;
  bit pend = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_host();
    for (int h = 0; h < NH; h++) if (host_req[h]) return h;
    return 0;
  endfunction

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++) if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    return -1;
  endfunction

  // Compare all outputs against the reference for the current inputs.
  task automatic check_now();
    int sh, dm, ds;
    logic [NH-1:0] eg, erv, eer;
    logic [NH-1:0][DW-1:0] erd;
    logic [ND-1:0] edr;
    sh = pick_host();
    dm = decode(host_addr[sh]);
    ds = (dm < 0) ? 0 : dm;
    eg = '0;
    if (host_req[sh]) eg[sh] = 1'b1;
    edr = '0;
    if (host_req[sh] && (dm >= 0 || !ERR_EN)) edr[ds] = 1'b1;
    chk("gnt", 128'(host_gnt), 128'(eg));
    chk("dev_req", 128'(dev_req), 128'(edr));
    for (int d = 0; d < ND; d++) begin
      chk("dev_addr", 128'(dev_addr[d]), 128'(host_addr[sh]));
      chk("dev_we", 128'(dev_we[d]), 128'(host_we[sh]));
      chk("dev_be", 128'(dev_be[d]), 128'(host_be[sh]));
      chk("dev_wdata", 128'(dev_wdata[d]), 128'(host_wdata[sh]));
    end
    erv = '0; eer = '0; erd = '0;
    if (pend) begin
      erv[rh] = 1'b1; eer[rh] = 1'b1;
    end else begin
      erv[rh] = dev_rvalid[rd]; eer[rh] = dev_err[rd]; erd[rh] = dev_rdata[rd];
    end
    chk("rvalid", 128'(host_rvalid), 128'(erv));
    chk("err", 128'(host_err), 128'(eer));
    chk("rdata", 128'(host_rdata), 128'(erd));
  endtask

  // Advance the reference across the next rising edge, then step off it.
  task automatic tick();
    int sh, dm;
    sh = pick_host();
    dm = decode(host_addr[sh]);
    @(posedge clk);
    if (!rst_n) begin
      rh = 0; rd = 0; pend = 1'b0;
    end else begin
      if (host_req[sh]) begin
        rh = sh; rd = (dm < 0) ? 0 : dm;
      end
      pend = ERR_EN && host_req[sh] && (dm < 0);
    end
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_now();
    tick();
  endtask

  task automatic idle();
    host_req = '0; host_we = '0; host_addr = '0; host_be = '0; host_wdata = '0;
    dev_rvalid = '0; dev_err = '0; dev_rdata = '0;
  endtask

  task automatic host_drive(input int h, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
    host_req[h] = 1'b1; host_we[h] = we; host_addr[h] = a;
    host_wdata[h] = wd; host_be[h] = be;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return 32'h0010_0000 | {12'h0, r[19:0]};
      1: return 32'h0002_0000 | {22'h0, r[9:0]};
      2: return 32'h0003_0000 | {22'h0, r[9:0]};
      3: return 32'h0005_0000;
      default: return r;
    endcase
  endfunction

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    idle();
    rst_n = 1'b0;

    // Reset, idle: everything quiet.
    @(negedge clk); check_now();
    chk("rst_gnt", 128'(host_gnt), 128'h0);
    chk("rst_dreq", 128'(dev_req), 128'h0);
    chk("rst_rvalid", 128'(host_rvalid), 128'h0);
    chk("rst_err", 128'(host_err), 128'h0);
    tick();
    // Combinational path still live during reset.
    host_drive(1, 1'b0, 32'h0002_0010, 32'h0, 4'hF);
    @(negedge clk); check_now();
    chk("rst_gnt1", 128'(host_gnt), 128'h2);
    chk("rst_dreq1", 128'(dev_req), 128'h2);
    tick();
    idle();
    rst_n = 1'b1;
    cycle();

    // Host0 read from dev0, response next cycle.
    host_drive(0, 1'b0, 32'h0010_0010, 32'h0, 4'hF);
    @(negedge clk); check_now();
    chk("rd_gnt0", 128'(host_gnt), 128'h1);
    chk("rd_dreq0", 128'(dev_req), 128'h1);
    tick();
    idle();
    dev_rvalid[0] = 1'b1; dev_rdata[0] = 32'hDEAD_BEEF;
    @(negedge clk); check_now();
    chk("rd_rvalid0", 128'(host_rvalid), 128'h1);
    chk("rd_rdata0", 128'(host_rdata[0]), 128'hDEAD_BEEF);
    tick();

    // Host0 write to dev1.
    idle();
    host_drive(0, 1'b1, 32'h0002_0000, 32'h41, 4'hF);
    @(negedge clk); check_now();
    chk("wr_dreq", 128'(dev_req), 128'h2);
    chk("wr_we", 128'(dev_we[1]), 128'h1);
    chk("wr_wdata", 128'(dev_wdata[1]), 128'h41);
    tick();

    // Contention: host0 wins, host1 waits until host0 drops.
    idle();
    host_drive(0, 1'b0, 32'h0003_0004, 32'h0, 4'hF);
    host_drive(1, 1'b0, 32'h0010_0000, 32'h0, 4'hF);
    @(negedge clk); check_now();
    chk("arb_gnt", 128'(host_gnt), 128'h1);
    chk("arb_dreq", 128'(dev_req), 128'h4);
    tick();
    // dev2 answers with an error while host0 still holds its request.
    dev_rvalid[2] = 1'b1; dev_err[2] = 1'b1;
    @(negedge clk); check_now();
    chk("dev2_err", 128'(host_err), 128'h1);
    chk("arb_hold", 128'(host_gnt), 128'h1);
    tick();
    host_req[0] = 1'b0; dev_rvalid = '0; dev_err = '0;
    @(negedge clk); check_now();
    chk("arb_gnt1", 128'(host_gnt), 128'h2);
    chk("arb_dreq1", 128'(dev_req), 128'h1);
    tick();

    // Unmapped address.
    idle();
    host_drive(0, 1'b0, 32'h0005_0000, 32'h0, 4'hF);
    @(negedge clk); check_now();
    chk("unmap_dreq", 128'(dev_req), ERR_EN ? 128'h0 : 128'h1);
    tick();
    idle();
    @(negedge clk); check_now();
    chk("unmap_rvalid", 128'(host_rvalid), ERR_EN ? 128'h1 : 128'h0);
    chk("unmap_err", 128'(host_err), ERR_EN ? 128'h1 : 128'h0);
    tick();

    // Random traffic with random device responses and a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      host_req = NH'($urandom);
      for (int h = 0; h < NH; h++)
        host_drive(h, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
      host_req = NH'($urandom);
      dev_rvalid = ND'($urandom);
      dev_err = ND'($urandom);
      for (int d = 0; d < ND; d++) dev_rdata[d] = $urandom;
      if (i == 200) begin
        rst_n = 1'b0;
        rh = 0; rd = 0; pend = 1'b0;
      end else if (i == 202) begin
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
